// File: rtl/sfp_norm.sv
// Row L1-sum and per-element fixed-point normalisation behind the psum memory.
// Optional macro SFP_RELU_EN: negative elements are clamped to zero before summing/dividing.
module sfp_norm #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int FRAC    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bw_psum*col-1:0]   in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [bw_psum+3:0]       sum_out,
    output logic                     sum_valid,
    output logic [bw_psum*col-1:0]   out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int SW = bw_psum + 4;
    localparam int DW = SW + FRAC + 1;
    localparam int KW = $clog2(FRAC + 1);
    localparam int IW = (col > 1) ? $clog2(col) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [bw_psum*col-1:0] row_q, row_d;
    logic [SW-1:0]          sum_q, sum_d;
    logic                   sum_valid_q, sum_valid_d;
    logic [bw_psum*col-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [KW-1:0]          bit_q, bit_d;
    logic [DW-1:0]          rem_q, rem_d;
    logic [FRAC:0]          quo_q, quo_d;

    function automatic logic [SW-1:0] mag(input logic [bw_psum-1:0] p);
        logic [SW-1:0] ext;
        ext = {{4{p[bw_psum-1]}}, p};
`ifdef SFP_RELU_EN
        return p[bw_psum-1] ? '0 : ext;
`else
        return p[bw_psum-1] ? -ext : ext;
`endif
    endfunction

    logic [SW-1:0]      sum_comb;
    logic [bw_psum-1:0] elem;
    logic [SW-1:0]      m_cur;
    logic               first;
    logic [DW-1:0]      rem_cur, divs, rem_nx;
    logic               ge;
    logic [FRAC:0]      q_nx;
    logic [bw_psum-1:0] qx, res;

    always_comb begin
        sum_comb = '0;
        for (int unsigned i = 0; i < col; i++) begin
            sum_comb = sum_comb + mag(row_q[i*bw_psum +: bw_psum]);
        end
    end

    // One quotient bit per cycle; the first bit of each element loads the dividend directly.
    always_comb begin
        elem    = row_q[int'(idx_q)*bw_psum +: bw_psum];
        m_cur   = mag(elem);
        first   = (bit_q == KW'(FRAC));
        rem_cur = first ? (DW'(m_cur) << FRAC) : rem_q;
        divs    = DW'(sum_q) << bit_q;
        ge      = (sum_q != '0) && (rem_cur >= divs);
        rem_nx  = ge ? (rem_cur - divs) : rem_cur;
        q_nx    = first ? '0 : quo_q;
        if (ge) begin
            q_nx[bit_q] = 1'b1;
        end
        qx = {{(bw_psum-FRAC-1){1'b0}}, q_nx};
`ifdef SFP_RELU_EN
        res = qx;
`else
        res = elem[bw_psum-1] ? -qx : qx;
`endif
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        bit_d       = bit_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    row_d       = in;
                    sum_valid_d = 1'b0;
                    state_d     = SUM;
                end
            end
            SUM: begin
                sum_d       = sum_comb;
                sum_valid_d = 1'b1;
                idx_d       = '0;
                bit_d       = KW'(FRAC);
                rem_d       = '0;
                quo_d       = '0;
                state_d     = DIV;
            end
            DIV: begin
                rem_d = rem_nx;
                quo_d = q_nx;
                if (bit_q == '0) begin
                    out_d[int'(idx_q)*bw_psum +: bw_psum] = res;
                    bit_d = KW'(FRAC);
                    if (idx_q == IW'(col - 1)) begin
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    bit_d = bit_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            bit_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm: directed rows, expected sums/rows queued at acceptance.
module tb_sfp_norm;

    localparam int COL = 8;
    localparam int BW  = 20;
    localparam int FR  = 8;
    localparam int LAT = 1 + COL * (FR + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [BW*COL-1:0]   in = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BW+3:0]       sum_out;
    logic                sum_valid;
    logic [BW*COL-1:0]   out;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                busy;

    sfp_norm #(.col(COL), .bw_psum(BW), .FRAC(FR)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .sum_out(sum_out), .sum_valid(sum_valid), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW+3:0]     sum;
        logic [BW*COL-1:0] row;
        int                acc;
    } exp_t;

    exp_t expq[$];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [BW*COL-1:0] act, input logic [BW*COL-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [BW*COL-1:0] mk(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        logic [BW*COL-1:0] r;
        int a[8];
        int v;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int i = 0; i < COL; i++) begin
            v = a[i];
            r[i*BW +: BW] = v[BW-1:0];
        end
        return r;
    endfunction

    // Called aligned at posedge+1; returns aligned at posedge+1 after the accepting edge.
    task automatic send(input logic [BW*COL-1:0] row, input logic [BW+3:0] es,
                        input logic [BW*COL-1:0] eo, output int acc);
        logic pre;
        int   n;
        exp_t e;
        n = 0;
        acc = -1;
        in = row;
        in_valid = 1'b1;
        while (acc < 0 && n < 300) begin
            @(negedge clk);
            pre = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (pre && reset) acc = cyc;
        end
        in_valid = 1'b0;
        in = ~row;
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.sum = es;
            e.row = eo;
            e.acc = acc;
            expq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expq.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: sum on sum_valid rise, latency on out_valid rise, data on handshake.
    initial begin
        logic psv, pov;
        psv = 1'b0;
        pov = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (sum_valid && !psv) begin
                    if (expq.size() == 0) chk("sum_unexpected", 0, 1);
                    else begin
                        chk("sum_out", sum_out, expq[0].sum);
                        chk("sum_lat", cyc, expq[0].acc + 1);
                    end
                end
                if (out_valid && !pov) begin
                    if (expq.size() == 0) chk("out_unexpected", 0, 1);
                    else chk("out_lat", cyc, expq[0].acc + LAT);
                end
                if (out_valid && out_ready && expq.size() != 0) begin
                    chk("out_row", out, expq[0].row);
                    chk("out_sum", sum_out, expq[0].sum);
                    void'(expq.pop_front());
                end
            end
            psv = sum_valid && reset;
            pov = out_valid && reset;
        end
    end

    initial begin
        int acc, acc_b, hcyc, n;
        logic [BW*COL-1:0] so;
        logic [BW+3:0]     ss;

        #23;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_out", out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        send(mk(1, 1, 1, 1, 1, 1, 1, 1), 8, mk(32, 32, 32, 32, 32, 32, 32, 32), acc);
        drain();
`ifdef SFP_RELU_EN
        send(mk(-4, 4, 0, 0, 0, 0, 0, 0), 4, mk(0, 256, 0, 0, 0, 0, 0, 0), acc);
`else
        send(mk(-4, 4, 0, 0, 0, 0, 0, 0), 8, mk(-128, 128, 0, 0, 0, 0, 0, 0), acc);
`endif
        drain();
        send(mk(100, 0, 0, 0, 0, 0, 0, 0), 100, mk(256, 0, 0, 0, 0, 0, 0, 0), acc);
        drain();
        send(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, mk(0, 0, 0, 0, 0, 0, 0, 0), acc);
        drain();
`ifdef SFP_RELU_EN
        send(mk(-524288, 0, 0, 0, 0, 0, 0, 0), 0, mk(0, 0, 0, 0, 0, 0, 0, 0), acc);
`else
        send(mk(-524288, 0, 0, 0, 0, 0, 0, 0), 524288, mk(-256, 0, 0, 0, 0, 0, 0, 0), acc);
`endif
        drain();
        send(mk(1, 2, 0, 0, 0, 0, 0, 0), 3, mk(85, 170, 0, 0, 0, 0, 0, 0), acc);
        drain();
`ifdef SFP_RELU_EN
        send(mk(-1, 2, 0, 0, 0, 0, 0, 0), 2, mk(0, 256, 0, 0, 0, 0, 0, 0), acc);
`else
        send(mk(-1, 2, 0, 0, 0, 0, 0, 0), 3, mk(-85, 170, 0, 0, 0, 0, 0, 0), acc);
`endif
        drain();

        // Back-pressure window with a second row offered while DONE is held.
        out_ready = 1'b0;
        send(mk(3, 1, 0, 0, 0, 0, 0, 0), 4, mk(192, 64, 0, 0, 0, 0, 0, 0), acc);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("hold_wait_timeout", 0, 1);
        so = out;
        ss = sum_out;
        hcyc = 0;
        fork
            begin
                send(mk(1, 2, 0, 0, 0, 0, 0, 0), 3, mk(85, 170, 0, 0, 0, 0, 0, 0), acc_b);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_out", out, so);
                    chk("hold_sum", sum_out, ss);
                    chk("hold_out_valid", out_valid, 1);
                    chk("hold_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(posedge clk); #1;
                hcyc = cyc;
            end
        join
        chk("accept_after_hs", acc_b, hcyc + 1);
        drain();

        // Asynchronous reset in the middle of DIV.
        send(mk(1, 1, 1, 1, 1, 1, 1, 1), 8, mk(32, 32, 32, 32, 32, 32, 32, 32), acc);
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum_valid", sum_valid, 0);
        chk("mid_rst_sum_out", sum_out, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out", out, 0);
        expq.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
`ifdef SFP_RELU_EN
        send(mk(-1, 2, 0, 0, 0, 0, 0, 0), 2, mk(0, 256, 0, 0, 0, 0, 0, 0), acc);
`else
        send(mk(-1, 2, 0, 0, 0, 0, 0, 0), 3, mk(-85, 170, 0, 0, 0, 0, 0, 0), acc);
`endif
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
